// File: rtl/ddram_arb.sv
// ddram_arb: shares the 64-bit DDRAM_* port between byte ports a_*/b_* (addr, din, rd, wr in; dout, ready out), each with a one-line read cache, misses served round-robin
module ddram_arb #(
  parameter logic [28:0] BASE = 29'h0600000,
  parameter int          AW   = 25
) (
  input  logic          clk_sys,
  input  logic          reset,
  input  logic [AW-1:0] a_addr,
  input  logic [7:0]    a_din,
  input  logic          a_rd,
  input  logic          a_wr,
  output logic [7:0]    a_dout,
  output logic          a_ready,
  input  logic [AW-1:0] b_addr,
  input  logic [7:0]    b_din,
  input  logic          b_rd,
  input  logic          b_wr,
  output logic [7:0]    b_dout,
  output logic          b_ready,
  input  logic          DDRAM_BUSY,
  output logic [7:0]    DDRAM_BURSTCNT,
  output logic [28:0]   DDRAM_ADDR,
  input  logic [63:0]   DDRAM_DOUT,
  input  logic          DDRAM_DOUT_READY,
  output logic          DDRAM_RD,
  output logic [63:0]   DDRAM_DIN,
  output logic [7:0]    DDRAM_BE,
  output logic          DDRAM_WE
);
  typedef enum logic [1:0] {IDLE, RD_ISSUE, RD_WAIT, WR_ISSUE} state_t;
  state_t        state;
  logic [AW-1:0] addr_i [2];
  logic [7:0]    din_i [2];
  logic          rd_i [2];
  logic          wr_i [2];
  logic [AW-1:0] req_addr [2];
  logic [7:0]    req_din [2];
  logic [7:0]    dout_r [2];
  logic          req_wr [2];
  logic          pend [2];
  logic          hit_st [2];
  logic          rdy [2];
  logic          rd_q [2];
  logic          wr_q [2];
  logic          cvalid [2];
  logic [AW-4:0] ctag [2];
  logic [63:0]   cline [2];
  logic          el [2];
  logic          grant, last, discard, g, wr_acc;
  logic [AW-1:0] g_addr;
  assign addr_i[0] = a_addr;
  assign addr_i[1] = b_addr;
  assign din_i[0] = a_din;
  assign din_i[1] = b_din;
  assign rd_i[0] = a_rd;
  assign rd_i[1] = b_rd;
  assign wr_i[0] = a_wr;
  assign wr_i[1] = b_wr;
  assign a_dout = dout_r[0];
  assign b_dout = dout_r[1];
  assign a_ready = rdy[0];
  assign b_ready = rdy[1];
  assign DDRAM_BURSTCNT = 8'd1;
  always_comb begin
    for (int p = 0; p < 2; p++) el[p] = pend[p] && (req_wr[p] || !discard);
    g = (el[0] && el[1]) ? ~last : el[1];
    g_addr = req_addr[grant];
    wr_acc = (state == WR_ISSUE) && !DDRAM_BUSY;
  end
  always_ff @(posedge clk_sys) begin
    for (int p = 0; p < 2; p++) begin
      rd_q[p] <= rd_i[p];
      wr_q[p] <= wr_i[p];
    end
    discard <= (discard && !DDRAM_DOUT_READY) ||
               (reset && (state == RD_WAIT || (state == RD_ISSUE && !DDRAM_BUSY)));
    if (reset) begin
      state <= IDLE;
      last <= 1'b1;
      grant <= 1'b0;
      DDRAM_RD <= 1'b0;
      DDRAM_WE <= 1'b0;
      DDRAM_ADDR <= BASE;
      DDRAM_BE <= 8'd0;
      DDRAM_DIN <= 64'd0;
      for (int p = 0; p < 2; p++) begin
        rdy[p] <= 1'b1;
        dout_r[p] <= 8'd0;
        pend[p] <= 1'b0;
        hit_st[p] <= 1'b0;
        cvalid[p] <= 1'b0;
        req_wr[p] <= 1'b0;
      end
    end else begin
      for (int p = 0; p < 2; p++) begin
        if (rdy[p] && ((rd_i[p] && !rd_q[p]) || (wr_i[p] && !wr_q[p]))) begin
          rdy[p] <= 1'b0;
          req_addr[p] <= addr_i[p];
          req_din[p] <= din_i[p];
          req_wr[p] <= wr_i[p] && !wr_q[p];
          if ((wr_i[p] && !wr_q[p]) || !(cvalid[p] && ctag[p] == addr_i[p][AW-1:3])) pend[p] <= 1'b1;
          else hit_st[p] <= 1'b1;
        end
        if (hit_st[p]) begin
          hit_st[p] <= 1'b0;
          rdy[p] <= 1'b1;
          dout_r[p] <= cline[p][{req_addr[p][2:0], 3'b000} +: 8];
        end
        if (wr_acc && cvalid[p] && ctag[p] == g_addr[AW-1:3])
          cline[p][{g_addr[2:0], 3'b000} +: 8] <= req_din[grant];
      end
      case (state)
        IDLE: if (el[0] || el[1]) begin
          grant <= g;
          if (el[0] && el[1]) last <= g;
          DDRAM_ADDR <= BASE + 29'(req_addr[g][AW-1:3]);
          DDRAM_BE <= 8'd1 << req_addr[g][2:0];
          DDRAM_DIN <= {8{req_din[g]}};
          DDRAM_WE <= req_wr[g];
          DDRAM_RD <= !req_wr[g];
          state <= req_wr[g] ? WR_ISSUE : RD_ISSUE;
        end
        RD_ISSUE: if (!DDRAM_BUSY) begin
          DDRAM_RD <= 1'b0;
          state <= RD_WAIT;
        end
        RD_WAIT: if (DDRAM_DOUT_READY) begin
          cvalid[grant] <= 1'b1;
          ctag[grant] <= g_addr[AW-1:3];
          cline[grant] <= DDRAM_DOUT;
          dout_r[grant] <= DDRAM_DOUT[{g_addr[2:0], 3'b000} +: 8];
          rdy[grant] <= 1'b1;
          pend[grant] <= 1'b0;
          state <= IDLE;
        end
        WR_ISSUE: if (!DDRAM_BUSY) begin
          DDRAM_WE <= 1'b0;
          rdy[grant] <= 1'b1;
          pend[grant] <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule
